// File: rtl/int_mem_arbiter.sv
// rtl/int_mem_arbiter.sv - shares the 8051 internal data RAM between core and aux master, owns its clear
module int_mem_arbiter #(
    parameter logic [7:0] AUX_WR_LO    = 8'h00,
    parameter logic [7:0] AUX_WR_HI    = 8'h7F,
    parameter int         AUX_MAX_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_req,
    output logic       init_done,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_we1_n,
    input  logic       cpu_we2_n,
    input  logic       cpu_rd_n,
    output logic [7:0] cpu_data_out,
    input  logic       aux_req,
    input  logic       aux_we,
    input  logic [7:0] aux_addr,
    input  logic [7:0] aux_wdata,
    output logic       aux_gnt,
    output logic       aux_rvalid,
    output logic [7:0] aux_rdata,
    output logic       aux_err,
    output logic       aux_starved,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    output logic       mem_we1_n,
    output logic       mem_we2_n,
    output logic       mem_rd_n,
    input  logic [7:0] mem_data_out
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam logic [7:0] MAX_WAIT = 8'(AUX_MAX_WAIT);

    state_t     state;
    logic [7:0] clr_cnt;
    logic [7:0] wait_cnt;
    logic       cpu_act;
    logic       aux_in_win;

    assign cpu_act = ~cpu_we1_n | ~cpu_we2_n | ~cpu_rd_n;
    // Offset-based range check: a single unsigned compare, valid while HI >= LO
    assign aux_in_win = (aux_addr - AUX_WR_LO) <= (AUX_WR_HI - AUX_WR_LO);

    always_comb begin
        aux_gnt      = 1'b0;
        mem_addr     = cpu_addr;
        mem_data_in  = cpu_data_in;
        mem_we1_n    = 1'b1;
        mem_we2_n    = 1'b1;
        mem_rd_n     = 1'b1;
        cpu_data_out = 8'h00;
        if (state == CLEAR) begin
            mem_addr    = clr_cnt;
            mem_data_in = 8'h00;
            mem_we1_n   = 1'b0;
        end else begin
            cpu_data_out = mem_data_out;
            if (cpu_act) begin
                mem_we1_n = cpu_we1_n;
                mem_we2_n = cpu_we2_n;
                mem_rd_n  = cpu_rd_n;
            end else if (aux_req) begin
                aux_gnt  = 1'b1;
                mem_addr = aux_addr;
                if (aux_we) begin
                    mem_data_in = aux_wdata;
                    mem_we1_n   = ~aux_in_win;
                end else begin
                    mem_rd_n = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            clr_cnt     <= 8'h00;
            init_done   <= 1'b0;
            aux_rvalid  <= 1'b0;
            aux_rdata   <= 8'h00;
            aux_err     <= 1'b0;
            aux_starved <= 1'b0;
            wait_cnt    <= 8'h00;
        end else begin
            aux_rvalid <= aux_gnt & ~aux_we;
            aux_err    <= aux_gnt & aux_we & ~aux_in_win;
            if (aux_gnt && !aux_we) begin
                aux_rdata <= mem_data_out;
            end

            if (clr_req) begin
                state       <= CLEAR;
                clr_cnt     <= 8'h00;
                init_done   <= 1'b0;
                aux_starved <= 1'b0;
                wait_cnt    <= 8'h00;
            end else begin
                if (state == CLEAR) begin
                    clr_cnt <= clr_cnt + 8'd1;
                    if (clr_cnt == 8'hFF) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                // Starvation counter saturates; the flag stays until reset or clear
                if (aux_gnt) begin
                    wait_cnt <= 8'h00;
                end else if (aux_req && wait_cnt != MAX_WAIT) begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wait_cnt == MAX_WAIT - 8'd1) begin
                        aux_starved <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_int_mem_arbiter.sv
// tb/tb_int_mem_arbiter.sv - directed self-checking bench for int_mem_arbiter with a 256x8 memory model
module tb_int_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_req;
    logic       init_done;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_data_in;
    logic       cpu_we1_n;
    logic       cpu_we2_n;
    logic       cpu_rd_n;
    logic [7:0] cpu_data_out;
    logic       aux_req;
    logic       aux_we;
    logic [7:0] aux_addr;
    logic [7:0] aux_wdata;
    logic       aux_gnt;
    logic       aux_rvalid;
    logic [7:0] aux_rdata;
    logic       aux_err;
    logic       aux_starved;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_we1_n;
    logic       mem_we2_n;
    logic       mem_rd_n;
    logic [7:0] mem_data_out;

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_we1_n || !mem_we2_n) mem[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = mem[mem_addr];

    int_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_done(init_done),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_we1_n(cpu_we1_n),
        .cpu_we2_n(cpu_we2_n), .cpu_rd_n(cpu_rd_n), .cpu_data_out(cpu_data_out),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .aux_err(aux_err), .aux_starved(aux_starved),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we1_n(mem_we1_n),
        .mem_we2_n(mem_we2_n), .mem_rd_n(mem_rd_n), .mem_data_out(mem_data_out)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        cpu_we1_n = 1'b1;
        cpu_we2_n = 1'b1;
        cpu_rd_n  = 1'b1;
    endtask

    task automatic core_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        cpu_addr = addr;
        cpu_rd_n = 1'b0;
        #1;
        check(tag, 16'(cpu_data_out), 16'(exp));
        cyc();
        cpu_rd_n = 1'b1;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (n < 400) begin
            cyc();
            n++;
            if (init_done) break;
        end
        check(tag, 16'(n), 16'd256);
    endtask

    task automatic aux_cycle(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        aux_req   = 1'b1;
        aux_we    = we;
        aux_addr  = addr;
        aux_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        rst_n = 1'b0; clr_req = 1'b0;
        cpu_addr = 8'h00; cpu_data_in = 8'h00; core_idle();
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = 8'h00; aux_wdata = 8'h00;
        repeat (3) cyc();
        check("rst_init_done", 16'(init_done), 16'd0);
        check("rst_outs", {12'h0, aux_rvalid, aux_err, aux_starved, aux_gnt}, 16'h0);
        check("rst_aux_rdata", 16'(aux_rdata), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init_latency");
        core_read("clr_rd_00", 8'h00, 8'h00);
        core_read("clr_rd_08", 8'h08, 8'h00);
        core_read("clr_rd_FF", 8'h FF, 8'h00);

        // Aux write with core idle
        aux_cycle(1'b1, 8'h08, 8'hA5);
        #1;
        check("aux_wr_gnt", 16'(aux_gnt), 16'd1);
        check("aux_wr_we1", 16'(mem_we1_n), 16'd0);
        cyc();
        aux_req = 1'b0;
        check("aux_wr_noerr", 16'(aux_err), 16'd0);
        core_read("aux_wr_readback", 8'h08, 8'hA5);

        // Core write holds off an aux read for 3 cycles
        cpu_addr = 8'h09; cpu_data_in = 8'h3C; cpu_we2_n = 1'b0;
        aux_cycle(1'b0, 8'h09, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("core_wins_gnt", 16'(aux_gnt), 16'd0);
            check("core_wins_addr", 16'(mem_addr), 16'h09);
            cyc();
        end
        cpu_we2_n = 1'b1;
        #1;
        check("aux_rd_gnt", 16'(aux_gnt), 16'd1);
        check("aux_rd_rdn", 16'(mem_rd_n), 16'd0);
        cyc();
        aux_req = 1'b0;
        check("aux_rd_rvalid", 16'(aux_rvalid), 16'd1);
        check("aux_rd_rdata", 16'(aux_rdata), 16'h3C);
        cyc();
        check("aux_rd_rvalid_pulse", 16'(aux_rvalid), 16'd0);

        // Writes outside / at edge of the window
        aux_cycle(1'b1, 8'h90, 8'h11);
        #1;
        check("oow_gnt", 16'(aux_gnt), 16'd1);
        check("oow_strobes", {14'h0, mem_we1_n, mem_we2_n}, 16'h3);
        cyc();
        aux_req = 1'b0;
        check("oow_err", 16'(aux_err), 16'd1);
        cyc();
        check("oow_err_pulse", 16'(aux_err), 16'd0);
        core_read("oow_unchanged", 8'h90, 8'h00);
        aux_cycle(1'b1, 8'h7F, 8'h5A);
        cyc();
        aux_req = 1'b0;
        check("win_hi_noerr", 16'(aux_err), 16'd0);
        core_read("win_hi_readback", 8'h7F, 8'h5A);

        // Starvation: core busy 20 cycles
        cpu_addr = 8'h20; cpu_rd_n = 1'b0;
        aux_cycle(1'b0, 8'h08, 8'h00);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 15) check("starve_pre", 16'(aux_starved), 16'd0);
            if (i == 16) check("starve_set", 16'(aux_starved), 16'd1);
        end
        cpu_rd_n = 1'b1;
        #1;
        check("starve_gnt", 16'(aux_gnt), 16'd1);
        cyc();
        aux_req = 1'b0;
        check("starve_sticky", 16'(aux_starved), 16'd1);
        check("starve_rdata", 16'(aux_rdata), 16'hA5);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        check("clr_starved", 16'(aux_starved), 16'd0);
        check("clr_init_done", 16'(init_done), 16'd0);
        wait_init("clr_latency");
        core_read("clr2_rd_08", 8'h08, 8'h00);

        // Async reset in the middle of a clear
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (100) cyc();
        check("mid_clr_addr", 16'(mem_addr), 16'd100);
        aux_cycle(1'b0, 8'h08, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_addr", 16'(mem_addr), 16'd0);
        check("async_outs", {12'h0, init_done, aux_rvalid, aux_err, aux_starved}, 16'h0);
        aux_req = 1'b0;
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("rst_restart_latency");
        check("rst_no_rvalid", 16'(aux_rvalid), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
